// File: rtl/regfile_write_scheduler.sv
// Write-side controller for the register file: sweeps INIT_VALUE into every register after
// reset/Restart, then arbitrates host and pipeline writeback writes onto the two write strobes.
module regfile_write_scheduler #(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter int                NUM_REGS   = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int                PROTECT_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Restart,
    input  logic              HostReq,
    input  logic [ADDR_W-1:0] HostAdd,
    input  logic [DATA_W-1:0] HostData,
    output logic              HostAck,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbAdd,
    input  logic [DATA_W-1:0] WbData,
    output logic              WbStall,
    output logic              Ready,
    output logic              WriteInitialiseSignal,
    output logic [ADDR_W-1:0] WriteInitialiseAdd,
    output logic [DATA_W-1:0] WriteInitialiseData,
    output logic              WriteDataBackSignal,
    output logic [ADDR_W-1:0] WriteBackAdd,
    output logic [DATA_W-1:0] WriteBackData
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W:0]   clearPtr;
    logic              skidValid;
    logic [ADDR_W-1:0] skidAdd;
    logic [DATA_W-1:0] skidData;
    logic              lastHost;

    logic running;
    logic grantHost;
    logic grantSkid;
    logic grantDirect;
    logic wbAccept;
    logic hostDrop;
    logic skidDrop;
    logic wbDrop;

    always_comb begin
        running     = (state == RUN) && !Restart;
        // Skid beats the host only right after a host grant, so neither side can starve.
        grantSkid   = running && skidValid && (lastHost || !HostReq);
        grantHost   = running && HostReq && !(skidValid && lastHost);
        WbStall     = !rst && ((state == CLEAR) || skidValid);
        wbAccept    = running && WbValid && !WbStall;
        grantDirect = wbAccept && !HostReq;
        HostAck     = grantHost;
        Ready       = (state == RUN);
        hostDrop    = (PROTECT_R0 != 0) && (HostAdd == '0);
        skidDrop    = (PROTECT_R0 != 0) && (skidAdd == '0);
        wbDrop      = (PROTECT_R0 != 0) && (WbAdd == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= CLEAR;
            clearPtr              <= '0;
            skidValid             <= 1'b0;
            skidAdd               <= '0;
            skidData              <= '0;
            lastHost              <= 1'b0;
            WriteInitialiseSignal <= 1'b0;
            WriteInitialiseAdd    <= '0;
            WriteInitialiseData   <= '0;
            WriteDataBackSignal   <= 1'b0;
            WriteBackAdd          <= '0;
            WriteBackData         <= '0;
        end else begin
            WriteInitialiseSignal <= 1'b0;
            WriteDataBackSignal   <= 1'b0;
            if (Restart) begin
                state     <= CLEAR;
                clearPtr  <= '0;
                skidValid <= 1'b0;
                lastHost  <= 1'b0;
            end else if (state == CLEAR) begin
                WriteInitialiseSignal <= 1'b1;
                WriteInitialiseAdd    <= clearPtr[ADDR_W-1:0];
                WriteInitialiseData   <= INIT_VALUE;
                clearPtr              <= clearPtr + 1'b1;
                if (clearPtr == LAST_PTR) begin
                    state <= RUN;
                end
            end else begin
                if (grantHost) begin
                    WriteInitialiseSignal <= !hostDrop;
                    WriteInitialiseAdd    <= HostAdd;
                    WriteInitialiseData   <= HostData;
                    lastHost              <= 1'b1;
                end else if (grantSkid) begin
                    WriteDataBackSignal <= !skidDrop;
                    WriteBackAdd        <= skidAdd;
                    WriteBackData       <= skidData;
                    skidValid           <= 1'b0;
                    lastHost            <= 1'b0;
                end else if (grantDirect) begin
                    WriteDataBackSignal <= !wbDrop;
                    WriteBackAdd        <= WbAdd;
                    WriteBackData       <= WbData;
                    lastHost            <= 1'b0;
                end
                if (wbAccept && !grantDirect) begin
                    skidValid <= 1'b1;
                    skidAdd   <= WbAdd;
                    skidData  <= WbData;
                end
            end
        end
    end

endmodule
